digit_entry_receiver: RTL

//   Receiving end of the keypad encoder's digit interface (4-bit BCD data plus active-low load strobe).
//   - Synchronizes the strobe and data into the clock domain.
//   - Shifts each accepted digit into a 3-digit mm:ss entry register (MIN, TENS, ONES), right to left.
//   - On start_req, hands the entry to the timer with a load_req/load_ack handshake.
//   - Locks out new entries while the magnetron is on.

---
 rtl/digit_entry_receiver.sv | 126 ++++++++++++
 1 files changed

// File: rtl/digit_entry_receiver.sv
// digit_entry_receiver: synchronizes keypad strobe/data, builds a 3-digit mm:ss entry
// and hands it to the timer with a load_req/load_ack handshake.
module digit_entry_receiver #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_loadn,
  input  logic [3:0] key_data,
  input  logic       clear,
  input  logic       start_req,
  input  logic       mag_on,
  input  logic       load_ack,
  output logic [3:0] min_bcd,
  output logic [3:0] tens_bcd,
  output logic [3:0] ones_bcd,
  output logic [1:0] digit_count,
  output logic       entry_valid,
  output logic       load_req,
  output logic       key_err
);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENTRY  = 2'd1;
  localparam logic [1:0] S_LOAD   = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;
  localparam int CW = $clog2(SYNC_STAGES + 1);
  logic [SYNC_STAGES-1:0]      loadn_sync_q, loadn_sync_d;
  logic [SYNC_STAGES-1:0][3:0] data_sync_q, data_sync_d;
  logic [CW-1:0]               fill_q, fill_d;
  logic                        armed_q, armed_d;
  logic                        mag_prev_q, mag_prev_d;
  logic [1:0]                  state_q, state_d;
  logic [3:0]                  min_q, min_d, tens_q, tens_d, ones_q, ones_d;
  logic [1:0]                  count_q, count_d;
  logic                        key_err_q, key_err_d;
  logic                        loadn_last, fill_done, key_ev, digit_ok, mag_fall;
  logic [3:0]                  key_digit;
  assign loadn_last  = loadn_sync_q[SYNC_STAGES-1];
  assign key_digit   = data_sync_q[SYNC_STAGES-1];
  assign fill_done   = fill_q == CW'(SYNC_STAGES);
  // The chain resets to "high", so only a high seen after it has refilled arms the edge detector;
  // this keeps a strobe held low across reset from producing an event.
  assign key_ev      = armed_q & ~loadn_last;
  assign digit_ok    = key_digit <= 4'd9;
  assign mag_fall    = mag_prev_q & ~mag_on;
  assign entry_valid = (count_q != 2'd0) && (tens_q <= 4'd5);
  assign load_req    = state_q == S_LOAD;
  assign min_bcd     = min_q;
  assign tens_bcd    = tens_q;
  assign ones_bcd    = ones_q;
  assign digit_count = count_q;
  assign key_err     = key_err_q;
  always_comb begin
    loadn_sync_d = {loadn_sync_q[SYNC_STAGES-2:0], key_loadn};
    data_sync_d  = {data_sync_q[SYNC_STAGES-2:0], key_data};
    fill_d       = fill_done ? fill_q : fill_q + CW'(1);
    armed_d      = fill_done & loadn_last;
    mag_prev_d   = mag_on;
  end
  always_comb begin
    state_d   = state_q;
    min_d     = min_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    count_d   = count_q;
    key_err_d = 1'b0;
    if (clear) begin
      state_d = S_IDLE;
      min_d   = 4'd0;
      tens_d  = 4'd0;
      ones_d  = 4'd0;
      count_d = 2'd0;
    end else if (state_q == S_LOAD) begin
      state_d   = load_ack ? S_LOCKED : S_LOAD;
      key_err_d = key_ev;
    end else if (state_q == S_LOCKED) begin
      key_err_d = key_ev;
      if (mag_fall) begin
        state_d = S_IDLE;
        min_d   = 4'd0;
        tens_d  = 4'd0;
        ones_d  = 4'd0;
        count_d = 2'd0;
      end
    end else if (state_q == S_ENTRY && start_req && entry_valid) begin
      state_d   = S_LOAD;
      key_err_d = key_ev;
    end else if (key_ev) begin
      key_err_d = ~digit_ok;
      if (digit_ok) begin
        state_d = S_ENTRY;
        min_d   = tens_q;
        tens_d  = ones_q;
        ones_d  = key_digit;
        count_d = (count_q == 2'd3) ? 2'd3 : count_q + 2'd1;
      end
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      loadn_sync_q <= '1;
      data_sync_q  <= '0;
      fill_q       <= '0;
      armed_q      <= 1'b0;
      mag_prev_q   <= 1'b0;
      state_q      <= S_IDLE;
      min_q        <= 4'd0;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      count_q      <= 2'd0;
      key_err_q    <= 1'b0;
    end else begin
      loadn_sync_q <= loadn_sync_d;
      data_sync_q  <= data_sync_d;
      fill_q       <= fill_d;
      armed_q      <= armed_d;
      mag_prev_q   <= mag_prev_d;
      state_q      <= state_d;
      min_q        <= min_d;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      count_q      <= count_d;
      key_err_q    <= key_err_d;
    end
  end
endmodule
